cache_ctrl_assoc: RTL and testbench
===================================

CACHE_CTRL_ASSOC -- requirements
Module: cache_ctrl_assoc

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH 32, byte address width; DATA_WIDTH 32, word width (fixed 32); SETS_LOG2 4, log2 of the set count; WORDS_LOG2 2, log2 of words per line; WAYS 2, associativity (power of 2, 1..8).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Ports SHALL be:
 clk  in  1  clock;
 rst  in  1  asynchronous active-high reset;
 req_valid  in  1  CPU access request;
 req_we  in  1  1 = store, 0 = load;
 req_addr  in  ADDR_WIDTH  byte address;
 req_wdata  in  32  store data, LSB-aligned;
 req_dtype  in  2  00 word, 01 byte, 10 halfword, 11 treated as word;
 resp_rdata  out  32  aligned word for loads;
 stall  out  1  request not yet complete;
 mem_req  out  1  backing-RAM request;
 mem_we  out  1  backing-RAM write;
 mem_addr  out  ADDR_WIDTH  word-aligned address;
 mem_wdata  out  32  write data, byte-lane positioned;
 mem_be  out  4  byte enables;
 mem_ack  in  1  RAM completes the current request this cycle;
 mem_rdata  in  32  read data, valid with mem_ack;
 hit_count  out  32  load-hit counter;
 miss_count  out  32  load-miss counter.

Function
REQ-004 The address split SHALL be: tag = upper ADDR_WIDTH-SETS_LOG2-WORDS_LOG2-2 bits, then set index, word offset and byte offset.
REQ-005 FSM states SHALL be IDLE, REFILL and WRITE; all other state encodings SHALL return to IDLE.
REQ-006 On a load hit in IDLE (any way valid with a matching tag), resp_rdata SHALL be the selected word in the same cycle, with stall=0 and zero added latency.
REQ-007 On a load miss in IDLE, stall SHALL be 1 combinationally, and the FSM SHALL go to REFILL with word counter 0.
REQ-008 In REFILL, mem_req SHALL be 1 and mem_we 0, with mem_addr = {tag, set, counter, 2'b00}; each mem_ack SHALL store mem_rdata into the victim line and increment the counter.
REQ-009 On the ack of word 2**WORDS_LOG2-1, the victim way SHALL have its tag written, its valid bit set and the set's round-robin pointer advanced, and the FSM SHALL return to IDLE; the held request then hits on the next cycle.
REQ-010 The victim SHALL be the lowest-index invalid way if one exists, else the set's round-robin pointer.
REQ-011 Stores SHALL be write-through and no-write-allocate: IDLE goes to WRITE with stall=1, and mem_req=1, mem_we=1 are held until mem_ack.
REQ-012 Byte enables SHALL be: word 1111; byte 0001<<addr[1:0]; halfword 0011<<{addr[1],1'b0}; mem_wdata SHALL be req_wdata replicated per lane.
REQ-013 On a store hit, the cached word SHALL be byte-merged under mem_be in the cycle mem_ack is seen; a store miss SHALL leave the cache unchanged.
REQ-014 Stall SHALL deassert in the cycle mem_ack completes a WRITE.
REQ-015 The CPU SHALL hold its request stable while stall=1; req_valid=0 in IDLE SHALL cause no state change and stall=0.
REQ-016 Outputs mem_req, mem_we and stall SHALL be 0 whenever the FSM is in IDLE with no miss or store pending.

Reset
REQ-017 Reset SHALL clear all valid bits, round-robin pointers, the word counter and both counters, and force the FSM to IDLE; mem_req and stall SHALL then read 0.
REQ-018 Reset asserted mid-REFILL SHALL leave no partially filled line valid.
REQ-019 Reset asserted mid-WRITE SHALL abandon the write without updating the cache.
REQ-020 Data and tag arrays SHALL NOT be reset.

Configuration
REQ-021 With CACHE_PERF_CNT_EN defined, hit_count SHALL increment on each IDLE load hit (excluding the post-refill replay hit) and miss_count on each load miss; both SHALL saturate at 32'hFFFF_FFFF.
REQ-022 Without CACHE_PERF_CNT_EN, hit_count and miss_count SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-023 Package cache_pkg SHALL hold the FSM state enum, the dtype constants and the byte-enable generation function.
REQ-024 Per-way tag/valid/data storage SHALL be one sub-module, cache_way_array, instantiated WAYS times by a generate loop.

Verification
REQ-025 Scenario: after reset, load 0x0000_1004 with RAM returning 0x11,0x22,0x33,0x44 for words 0-3 and mem_ack on each -> 4 REFILL reads at 0x1000-0x100C, then resp_rdata=0x22 with stall=0.
REQ-026 Scenario: immediately load 0x0000_100C -> hit, resp_rdata=0x44 in the same cycle, mem_req=0.
REQ-027 Scenario: store byte 0xAB to 0x0000_1005 -> mem_be=0010, mem_wdata=0xABABABAB; a subsequent load of 0x1004 returns 0x0000AB22 without a refill.
REQ-028 Scenario: load 0x1000, 0x2000, 0x3000 (same set, WAYS=2) -> the third refill evicts way 0 (0x1000); reloading 0x1000 misses.
REQ-029 Scenario: assert rst after 2 REFILL acks -> stall=0 and FSM in IDLE; reloading the same address performs a full 4-word refill.
REQ-030 Scenario: with CACHE_PERF_CNT_EN defined, run REQ-025 through REQ-026 -> miss_count=1, hit_count=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache controller:
// FSM state encoding, access-size codes and store lane generation.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REFILL = 2'b01,
    ST_WRITE  = 2'b10
  } state_t;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_BYTE = 2'b01;
  localparam logic [1:0] DT_HALF = 2'b10;

  function automatic logic [3:0] gen_be(input logic [1:0] dtype, input logic [1:0] addr_lo);
    case (dtype)
      DT_BYTE: gen_be = 4'b0001 << addr_lo;
      DT_HALF: gen_be = 4'b0011 << {addr_lo[1], 1'b0};
      default: gen_be = 4'b1111;
    endcase
  endfunction

  // Replicating the store value across lanes lets mem_be alone pick the target bytes.
  function automatic logic [31:0] gen_wdata(input logic [1:0] dtype, input logic [31:0] data);
    case (dtype)
      DT_BYTE: gen_wdata = {4{data[7:0]}};
      DT_HALF: gen_wdata = {2{data[15:0]}};
      default: gen_wdata = data;
    endcase
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid bit (reset), tag and line data (not reset).
// Reads are combinational; writes land on the clock edge.
module cache_way_array #(
  parameter int TAG_W      = 26,
  parameter int SETS_LOG2  = 4,
  parameter int WORDS_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SETS_LOG2-1:0]  set_idx,
  input  logic [WORDS_LOG2-1:0] rd_word,
  output logic                  valid,
  output logic [TAG_W-1:0]      tag,
  output logic [31:0]           rdata,
  input  logic                  wr_en,
  input  logic [WORDS_LOG2-1:0] wr_word,
  input  logic [3:0]            wr_be,
  input  logic [31:0]           wr_data,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag
);
  localparam int SETS       = 1 << SETS_LOG2;
  localparam int LINE_WORDS = 1 << WORDS_LOG2;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS*LINE_WORDS];

  assign valid = valid_q[set_idx];
  assign tag   = tag_q[set_idx];
  assign rdata = data_q[{set_idx, rd_word}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (fill_en) valid_q[set_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill_en) tag_q[set_idx] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_q[{set_idx, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// Set-associative, write-through / no-write-allocate cache controller with
// round-robin replacement. Define CACHE_PERF_CNT_EN to enable hit/miss counters.
module cache_ctrl_assoc
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS_LOG2  = 4,
  parameter int WORDS_LOG2 = 2,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_dtype,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int OFF_W = WORDS_LOG2 + 2;
  localparam int TAG_W = ADDR_WIDTH - SETS_LOG2 - OFF_W;
  localparam int SETS  = 1 << SETS_LOG2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_W-1:0]      req_tag;
  logic [SETS_LOG2-1:0]  req_set;
  logic [WORDS_LOG2-1:0] req_word;

  assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_set  = req_addr[OFF_W +: SETS_LOG2];
  assign req_word = req_addr[2 +: WORDS_LOG2];

  state_t                state_q, state_d;
  logic [WORDS_LOG2-1:0] cnt_q;
  logic [WAY_W-1:0]      victim_q, victim_c;
  logic [WAY_W-1:0]      rr_q [SETS];
  logic                  replay_q;

  logic [WAYS-1:0]  way_valid, way_hit, way_wr, way_fill;
  logic [TAG_W-1:0] way_tag   [WAYS];
  logic [31:0]      way_rdata [WAYS];
  logic             hit, load_hit, load_miss, refill_done;
  logic [31:0]      hit_rdata;

  logic [WORDS_LOG2-1:0] wr_word;
  logic [31:0]           wr_data;
  logic [3:0]            wr_be;

  assign wr_word = (state_q == ST_REFILL) ? cnt_q : req_word;
  assign wr_data = (state_q == ST_REFILL) ? mem_rdata : mem_wdata;
  assign wr_be   = (state_q == ST_REFILL) ? 4'b1111 : mem_be;

  genvar w;
  generate
    for (w = 0; w < WAYS; w++) begin : g_way
      assign way_hit[w]  = way_valid[w] && (way_tag[w] == req_tag);
      assign way_wr[w]   = mem_ack && (((state_q == ST_REFILL) && (victim_q == WAY_W'(w))) ||
                                       ((state_q == ST_WRITE) && way_hit[w]));
      assign way_fill[w] = refill_done && (victim_q == WAY_W'(w));

      cache_way_array #(
        .TAG_W      (TAG_W),
        .SETS_LOG2  (SETS_LOG2),
        .WORDS_LOG2 (WORDS_LOG2)
      ) u_way (
        .clk      (clk),
        .rst      (rst),
        .set_idx  (req_set),
        .rd_word  (req_word),
        .valid    (way_valid[w]),
        .tag      (way_tag[w]),
        .rdata    (way_rdata[w]),
        .wr_en    (way_wr[w]),
        .wr_word  (wr_word),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .fill_en  (way_fill[w]),
        .fill_tag (req_tag)
      );
    end
  endgenerate

  always_comb begin
    hit_rdata = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (way_hit[i]) hit_rdata = hit_rdata | way_rdata[i];
    end
  end

  // Lowest invalid way wins; scanning downward leaves the lowest one assigned last.
  always_comb begin
    victim_c = rr_q[req_set];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) victim_c = WAY_W'(i);
    end
  end

  assign hit         = |way_hit;
  assign load_hit    = (state_q == ST_IDLE) && req_valid && !req_we && hit;
  assign load_miss   = (state_q == ST_IDLE) && req_valid && !req_we && !hit;
  assign refill_done = (state_q == ST_REFILL) && mem_ack && (cnt_q == '1);

  assign resp_rdata = hit_rdata;
  assign mem_wdata  = gen_wdata(req_dtype, req_wdata);
  assign mem_be     = gen_be(req_dtype, req_addr[1:0]);
  assign mem_addr   = (state_q == ST_REFILL) ? {req_tag, req_set, cnt_q, 2'b00}
                                             : {req_addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_we) begin
          stall   = 1'b1;
          state_d = ST_WRITE;
        end else if (load_miss) begin
          stall   = 1'b1;
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (refill_done) state_d = ST_IDLE;
      end
      ST_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        stall   = !mem_ack;
        if (mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      victim_q <= '0;
      replay_q <= 1'b0;
      for (int i = 0; i < SETS; i++) rr_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      replay_q <= refill_done;
      if (state_q == ST_IDLE) cnt_q <= '0;
      else if ((state_q == ST_REFILL) && mem_ack) cnt_q <= cnt_q + 1'b1;
      if (load_miss) victim_q <= victim_c;
      if (refill_done) begin
        rr_q[req_set] <= (rr_q[req_set] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_set] + 1'b1;
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] hit_q, miss_q;

  // The hit replayed right after a refill belongs to the miss already counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (load_hit && !replay_q) hit_q <= sat_inc(hit_q);
      if (load_miss) miss_q <= sat_inc(miss_q);
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Bench for cache_ctrl_assoc: directed vector table, reset corner cases and a
// randomized run against a transaction-level cache model.
module tb_cache_ctrl_assoc;

`ifdef CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_dtype = '0;
  logic [31:0] resp_rdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_count, miss_count;

  cache_ctrl_assoc dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_dtype(req_dtype), .resp_rdata(resp_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Backing RAM covering byte addresses 0x0000-0x7FFF.
  logic [31:0] ram [8192];
  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram[a[14:2]];
  endfunction

  logic nodelay  = 1'b1;
  logic hold_ack = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      mem_ack   = mem_req && !hold_ack && (nodelay || ($urandom_range(0, 2) == 0));
      mem_rdata = mem_ack ? ram_rd(mem_addr) : 32'h0;
    end
  end

  int          rd_cnt = 0, wr_cnt = 0;
  logic [31:0] rd_log [16];
  logic [3:0]  last_be = '0;
  logic [31:0] last_wd = '0;

  always @(posedge clk) begin
    if (mem_req && mem_ack && !mem_we) begin
      rd_log[rd_cnt % 16] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_req && mem_ack && mem_we) begin
      wr_cnt  <= wr_cnt + 1;
      last_be <= mem_be;
      last_wd <= mem_wdata;
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr[14:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // One CPU access: present, hold while stalled, sample when stall drops.
  task automatic run_xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] dt, output logic [31:0] rd, output int nreads,
                          output int nwrites, output int rd_start, output logic mreq_done,
                          output logic ok);
    int w0;
    @(posedge clk); #1;
    rd_start = rd_cnt;
    w0 = wr_cnt;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_dtype = dt;
    ok = 1'b0; rd = '0; mreq_done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (!stall) begin
        rd = resp_rdata; mreq_done = mem_req; ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    nreads  = rd_cnt - rd_start;
    nwrites = wr_cnt - w0;
  endtask

  function automatic logic [3:0] model_be(input logic [1:0] dt, input logic [31:0] a);
    if (dt == 2'b01) return 4'(1 << (a % 4));
    if (dt == 2'b10) return ((a & 2) != 0) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] dt, input logic [31:0] d);
    if (dt == 2'b01) return (d & 32'hFF) * 32'h0101_0101;
    if (dt == 2'b10) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  dt;
    logic [31:0] exp_rd;
    int          exp_reads;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t tbl [14];

  // Transaction-level model state for the random phase.
  bit          mv   [16][2];
  logic [31:0] mtag [16][2];
  logic [31:0] mdat [16][2][4];
  int          mrr  [16];
  int          mhit, mmiss;

  logic [31:0] rd, a, d, exp_rd, exp_mid;
  int          nr, nw, rs, ws, way, st, tg, wo;
  logic        mq, ok, is_we;
  logic [1:0]  dt;
  logic [3:0]  ebe;
  int          ok_addr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    ram[32'h1000 >> 2] = 32'h11; ram[32'h1004 >> 2] = 32'h22;
    ram[32'h1008 >> 2] = 32'h33; ram[32'h100C >> 2] = 32'h44;

    tbl[0]  = '{1'b0, 32'h1004, 32'h0,         2'd0, 32'h22,             4, 4'h0, 32'h0};
    tbl[1]  = '{1'b0, 32'h100C, 32'h0,         2'd0, 32'h44,             0, 4'h0, 32'h0};
    tbl[2]  = '{1'b1, 32'h1005, 32'h1234_56AB, 2'd1, 32'h0,              0, 4'h2, 32'hABAB_ABAB};
    tbl[3]  = '{1'b0, 32'h1004, 32'h0,         2'd0, 32'h0000_AB22,      0, 4'h0, 32'h0};
    tbl[4]  = '{1'b0, 32'h2000, 32'h0,         2'd0, ram_rd(32'h2000),   4, 4'h0, 32'h0};
    tbl[5]  = '{1'b0, 32'h3000, 32'h0,         2'd0, ram_rd(32'h3000),   4, 4'h0, 32'h0};
    tbl[6]  = '{1'b0, 32'h2004, 32'h0,         2'd0, ram_rd(32'h2004),   0, 4'h0, 32'h0};
    tbl[7]  = '{1'b0, 32'h1000, 32'h0,         2'd0, 32'h11,             4, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 32'h3008, 32'h0,         2'd0, ram_rd(32'h3008),   0, 4'h0, 32'h0};
    tbl[9]  = '{1'b1, 32'h1002, 32'h7777_BEEF, 2'd2, 32'h0,              0, 4'hC, 32'hBEEF_BEEF};
    tbl[10] = '{1'b0, 32'h1000, 32'h0,         2'd0, 32'hBEEF_0011,      0, 4'h0, 32'h0};
    tbl[11] = '{1'b1, 32'h5000, 32'hDEAD_BEEF, 2'd3, 32'h0,              0, 4'hF, 32'hDEAD_BEEF};
    tbl[12] = '{1'b0, 32'h5000, 32'h0,         2'd0, 32'hDEAD_BEEF,      4, 4'h0, 32'h0};
    tbl[13] = '{1'b0, 32'h3000, 32'h0,         2'd0, ram_rd(32'h3000),   4, 4'h0, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].dt, rd, nr, nw, rs, mq, ok);
      chk($sformatf("row%0d_done", i), {31'd0, ok}, 32'd1);
      chk($sformatf("row%0d_reads", i), nr, tbl[i].exp_reads);
      if (tbl[i].we) begin
        chk($sformatf("row%0d_writes", i), nw, 32'd1);
        chk($sformatf("row%0d_be", i), {28'd0, last_be}, {28'd0, tbl[i].exp_be});
        chk($sformatf("row%0d_wdata", i), last_wd, tbl[i].exp_wd);
      end else begin
        chk($sformatf("row%0d_rdata", i), rd, tbl[i].exp_rd);
        chk($sformatf("row%0d_mem_req_at_resp", i), {31'd0, mq}, 32'd0);
        if (nr == 4) begin
          ok_addr = 1;
          for (int k = 0; k < 4; k++)
            if (rd_log[(rs + k) % 16] !== ((tbl[i].addr & 32'hFFFF_FFF0) + 32'(4 * k))) ok_addr = 0;
          chk($sformatf("row%0d_refill_addrs", i), ok_addr, 32'd1);
        end
      end
      if (i == 1) begin
        chk("perf_hit_after_first_hit", hit_count, PERF ? 32'd1 : 32'd0);
        chk("perf_miss_after_first_hit", miss_count, PERF ? 32'd1 : 32'd0);
      end
    end
    chk("perf_hit_table", hit_count, PERF ? 32'd5 : 32'd0);
    chk("perf_miss_table", miss_count, PERF ? 32'd6 : 32'd0);

    // Reset in the middle of a refill.
    @(posedge clk); #1;
    rs = rd_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1004; req_dtype = 2'd0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rd_cnt - rs >= 2) break;
    end
    chk("mid_refill_acks", rd_cnt - rs, 32'd2);
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("mid_refill_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_refill_rst_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_xact(1'b0, 32'h1004, 32'h0, 2'd0, rd, nr, nw, rs, mq, ok);
    chk("after_refill_rst_reads", nr, 32'd4);
    chk("after_refill_rst_rdata", rd, 32'h0000_AB22);

    // Reset in the middle of a write; the store must not land anywhere.
    exp_mid = ram_rd(32'h1004);
    hold_ack = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1004; req_wdata = 32'hCAFE_F00D; req_dtype = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("mid_write_stall", {31'd0, stall}, 32'd1);
    chk("mid_write_mem_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("mid_write_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_write_rst_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); rst = 1'b0; hold_ack = 1'b0;
    run_xact(1'b0, 32'h1004, 32'h0, 2'd0, rd, nr, nw, rs, mq, ok);
    chk("after_write_rst_reads", nr, 32'd4);
    chk("after_write_rst_rdata", rd, exp_mid);

    // Randomized phase from a clean reset with random RAM latency.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int s = 0; s < 16; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < 2; w++) mv[s][w] = 1'b0;
    end
    mhit = 0; mmiss = 0;
    nodelay = 1'b0;

    for (int it = 0; it < 300; it++) begin
      a = 32'h6000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 1)) << 4)
          | 32'($urandom_range(0, 15));
      d = $urandom;
      dt = 2'($urandom_range(0, 3));
      is_we = ($urandom_range(0, 9) < 3);
      st = int'((a >> 4) % 16); tg = int'(a >> 8); wo = int'((a >> 2) % 4);
      way = -1;
      for (int w = 0; w < 2; w++) if (mv[st][w] && mtag[st][w] == 32'(tg)) way = w;
      if (!is_we) begin
        if (way >= 0) begin
          mhit++;
          nr = 0;
        end else begin
          mmiss++;
          way = mrr[st];
          for (int w = 1; w >= 0; w--) if (!mv[st][w]) way = w;
          for (int k = 0; k < 4; k++) mdat[st][way][k] = ram_rd((a & 32'hFFFF_FFF0) + 32'(4 * k));
          mv[st][way] = 1'b1; mtag[st][way] = 32'(tg);
          mrr[st] = (mrr[st] + 1) % 2;
          nr = 4;
        end
        exp_rd = mdat[st][way][wo];
        run_xact(1'b0, a, d, dt, rd, ws, nw, rs, mq, ok);
        chk($sformatf("rnd%0d_done", it), {31'd0, ok}, 32'd1);
        chk($sformatf("rnd%0d_reads", it), ws, nr);
        chk($sformatf("rnd%0d_rdata", it), rd, exp_rd);
      end else begin
        ebe = model_be(dt, a);
        if (way >= 0)
          for (int b = 0; b < 4; b++)
            if (ebe[b]) mdat[st][way][wo][8*b +: 8] = model_wd(dt, d) >> (8 * b);
        run_xact(1'b1, a, d, dt, rd, ws, nw, rs, mq, ok);
        chk($sformatf("rnd%0d_done", it), {31'd0, ok}, 32'd1);
        chk($sformatf("rnd%0d_writes", it), nw, 32'd1);
        chk($sformatf("rnd%0d_be", it), {28'd0, last_be}, {28'd0, ebe});
        chk($sformatf("rnd%0d_wdata", it), last_wd, model_wd(dt, d));
      end
    end
    chk("rnd_hit_count", hit_count, PERF ? 32'(mhit) : 32'd0);
    chk("rnd_miss_count", miss_count, PERF ? 32'(mmiss) : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
